// File: rtl/gold_router_vc.sv
// gold_router_vc: three-port (cw, ccw, PE) ring router with two virtual channels.
//
// Each input has one FIFO per VC and each output has one single-entry register per VC.
// The VCs alternate roles every cycle. The VC equal to polarity is in its external
// phase: inputs fill their FIFO[polarity] and outputs present outreg[polarity]. The
// other VC is in its internal phase: FIFO heads move into outregs, with arbitration.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   polarity                 current phase (0 = even, 1 = odd)
//   cwsi/ccwsi/pesi          input valid     cwri/ccwri/peri   input ready
//   cwdi/ccwdi/pedi          input packets
//   cwso/ccwso/peso          output valid    cwro/ccwro/pero   downstream ready
//   cwdo/ccwdo/pedo          output packets; the VC bit is forced to polarity
module gold_router_vc #(
    parameter int unsigned PACKET_SIZE = 64,
    parameter int unsigned BUF_DEPTH   = 2,
    parameter int unsigned HOP_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   polarity,
    input  logic                   cwsi,
    input  logic                   ccwsi,
    input  logic                   pesi,
    output logic                   cwri,
    output logic                   ccwri,
    output logic                   peri,
    input  logic [PACKET_SIZE-1:0] cwdi,
    input  logic [PACKET_SIZE-1:0] ccwdi,
    input  logic [PACKET_SIZE-1:0] pedi,
    output logic                   cwso,
    output logic                   ccwso,
    output logic                   peso,
    input  logic                   cwro,
    input  logic                   ccwro,
    input  logic                   pero,
    output logic [PACKET_SIZE-1:0] cwdo,
    output logic [PACKET_SIZE-1:0] ccwdo,
    output logic [PACKET_SIZE-1:0] pedo
);

    localparam int unsigned PW     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW     = $clog2(BUF_DEPTH + 1);
    localparam int unsigned HOP_HI = PACKET_SIZE - 9;

    typedef logic [PACKET_SIZE-1:0] pkt_t;

    // Port index 0 = cw, 1 = ccw, 2 = PE (for inputs and outputs alike)
    logic          polarity_q;
    pkt_t          fifo_mem_q [3][2][BUF_DEPTH];
    logic [PW-1:0] rd_ptr_q   [3][2];
    logic [PW-1:0] wr_ptr_q   [3][2];
    logic [CW-1:0] count_q    [3][2];
    logic          out_vld_q  [3][2];
    pkt_t          out_dat_q  [3][2];
    logic          rr_ptr_q   [3][2];

    logic       pol, ip;
    logic [2:0] in_vld, in_rdy, out_rdy, push, pop, head_req, mv_en, rr_flip;
    pkt_t       in_dat [3];
    pkt_t       head_mv [3];
    logic [1:0] head_tgt [3];
    pkt_t       mv_dat [3];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pol      = polarity_q;
    assign ip       = ~polarity_q;
    assign polarity = polarity_q;

    assign in_vld  = {pesi, ccwsi, cwsi};
    assign out_rdy = {pero, ccwro, cwro};
    assign in_dat[0] = cwdi;
    assign in_dat[1] = ccwdi;
    assign in_dat[2] = pedi;

    // External phase: accept into FIFO[polarity] whenever it has room
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            in_rdy[i] = (count_q[i][pol] != CW'(BUF_DEPTH));
            push[i]   = in_vld[i] & in_rdy[i];
        end
    end

    assign cwri  = in_rdy[0];
    assign ccwri = in_rdy[1];
    assign peri  = in_rdy[2];

    // Internal phase: route each FIFO[!polarity] head and rewrite its hop field
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            head_mv[i]  = fifo_mem_q[i][ip][rd_ptr_q[i][ip]];
            head_req[i] = (count_q[i][ip] != '0);
            head_tgt[i] = 2'd2;
            if (i == 2) begin
                head_tgt[i] = head_mv[i][PACKET_SIZE-2] ? 2'd1 : 2'd0;
            end else if (head_mv[i][HOP_HI -: HOP_W] != '0) begin
                head_tgt[i] = 2'(i);
                head_mv[i][HOP_HI -: HOP_W] = head_mv[i][HOP_HI -: HOP_W] >> 1;
            end
        end
    end

    // Per-output arbitration on VC !polarity between a ring-side contender (r)
    // and the other contender (x); pointer 0 favours r.
    always_comb begin
        int   r, x;
        logic req_r, req_x, pick_x, free;
        pop     = '0;
        mv_en   = '0;
        rr_flip = '0;
        for (int o = 0; o < 3; o++) begin
            r         = (o == 2) ? 0 : o;
            x         = (o == 2) ? 1 : 2;
            req_r     = head_req[r] && (head_tgt[r] == 2'(o));
            req_x     = head_req[x] && (head_tgt[x] == 2'(o));
            free      = ~out_vld_q[o][ip];
            pick_x    = req_x && (!req_r || rr_ptr_q[o][ip]);
            mv_dat[o] = pick_x ? head_mv[x] : head_mv[r];
            mv_en[o]  = free && (req_r || req_x);
            rr_flip[o] = free && req_r && req_x;
            if (mv_en[o]) begin
                pop[pick_x ? x : r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            polarity_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int v = 0; v < 2; v++) begin
                    rd_ptr_q[i][v]  <= '0;
                    wr_ptr_q[i][v]  <= '0;
                    count_q[i][v]   <= '0;
                    out_vld_q[i][v] <= 1'b0;
                    rr_ptr_q[i][v]  <= 1'b0;
                end
            end
        end else begin
            polarity_q <= ~polarity_q;
            // FIFO[pol] only pushes and FIFO[!pol] only pops, so no shared-counter case
            for (int i = 0; i < 3; i++) begin
                if (push[i]) begin
                    fifo_mem_q[i][pol][wr_ptr_q[i][pol]] <= in_dat[i];
                    wr_ptr_q[i][pol] <= ptr_inc(wr_ptr_q[i][pol]);
                    count_q[i][pol]  <= count_q[i][pol] + CW'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i][ip] <= ptr_inc(rd_ptr_q[i][ip]);
                    count_q[i][ip]  <= count_q[i][ip] - CW'(1);
                end
            end
            for (int o = 0; o < 3; o++) begin
                if (out_vld_q[o][pol] && out_rdy[o]) begin
                    out_vld_q[o][pol] <= 1'b0;
                end
                if (mv_en[o]) begin
                    out_vld_q[o][ip] <= 1'b1;
                    out_dat_q[o][ip] <= mv_dat[o];
                end
                if (rr_flip[o]) begin
                    rr_ptr_q[o][ip] <= ~rr_ptr_q[o][ip];
                end
            end
        end
    end

    // Valids are gated so they read 0 while reset is held, even before the first edge
    always_comb begin
        cwso  = out_vld_q[0][pol] & ~reset;
        ccwso = out_vld_q[1][pol] & ~reset;
        peso  = out_vld_q[2][pol] & ~reset;
        cwdo  = out_dat_q[0][pol];
        ccwdo = out_dat_q[1][pol];
        pedo  = out_dat_q[2][pol];
        cwdo[PACKET_SIZE-1]  = pol;
        ccwdo[PACKET_SIZE-1] = pol;
        pedo[PACKET_SIZE-1]  = pol;
    end

endmodule

// File: tb/tb_gold_router_vc.sv
module tb_gold_router_vc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        polarity;
    logic        cwsi = 1'b0, ccwsi = 1'b0, pesi = 1'b0;
    logic        cwri, ccwri, peri;
    logic [63:0] cwdi = '0, ccwdi = '0, pedi = '0;
    logic        cwso, ccwso, peso;
    logic        cwro = 1'b1, ccwro = 1'b1, pero = 1'b1;
    logic [63:0] cwdo, ccwdo, pedo;

    int tests = 0;
    int fails = 0;

    gold_router_vc #(.PACKET_SIZE(64), .BUF_DEPTH(2), .HOP_W(8)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .cwsi(cwsi), .ccwsi(ccwsi), .pesi(pesi),
        .cwri(cwri), .ccwri(ccwri), .peri(peri),
        .cwdi(cwdi), .ccwdi(ccwdi), .pedi(pedi),
        .cwso(cwso), .ccwso(ccwso), .peso(peso),
        .cwro(cwro), .ccwro(ccwro), .pero(pero),
        .cwdo(cwdo), .ccwdo(ccwdo), .pedo(pedo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic vc, input logic dir, input logic [7:0] hop,
                                       input logic [47:0] pl);
        return {vc, dir, 6'h15, hop, pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pol(input logic p);
        for (int n = 0; n < 4 && polarity !== p; n++) tick();
        tests++;
        if (polarity !== p) begin
            fails++;
            $display("FAIL wait_pol: polarity=%b required %b", polarity, p);
        end
    endtask

    task automatic test_reset();
        logic exp_pol;
        reset = 1'b1;
        repeat (5) tick();
        tests++;
        if ({cwso, ccwso, peso} !== 3'b000) begin
            fails++;
            $display("FAIL reset_so_during: so=%b required 000", {cwso, ccwso, peso});
        end
        reset = 1'b0;
        exp_pol = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (polarity !== exp_pol) begin
                fails++;
                $display("FAIL reset_polarity[%0d]: got %b required %b", c, polarity, exp_pol);
            end
            tests++;
            if ({cwri, ccwri, peri} !== 3'b111 || {cwso, ccwso, peso} !== 3'b000) begin
                fails++;
                $display("FAIL reset_ri_so[%0d]: ri=%b so=%b required 111/000", c,
                         {cwri, ccwri, peri}, {cwso, ccwso, peso});
            end
            exp_pol = ~exp_pol;
            tick();
        end
    endtask

    task automatic test_cw_forward();
        logic [63:0] exp;
        wait_pol(1'b0);
        cwsi = 1'b1;
        cwdi = mk(1'b1, 1'b0, 8'h0F, 48'h1234_5678_9ABC);
        exp  = mk(1'b0, 1'b0, 8'h07, 48'h1234_5678_9ABC);
        tests++;
        if (cwri !== 1'b1) begin
            fails++;
            $display("FAIL cw_fwd_ready: cwri=%b required 1", cwri);
        end
        tick();
        cwsi = 1'b0;
        tests++;
        if (cwso !== 1'b0) begin
            fails++;
            $display("FAIL cw_fwd_early: cwso=%b required 0", cwso);
        end
        tick();
        tests++;
        if (cwso !== 1'b1 || cwdo !== exp) begin
            fails++;
            $display("FAIL cw_fwd_data: cwso=%b cwdo=%h required 1/%h", cwso, cwdo, exp);
        end
        tests++;
        if ({ccwso, peso} !== 2'b00) begin
            fails++;
            $display("FAIL cw_fwd_others: ccwso/peso=%b required 00", {ccwso, peso});
        end
        tick();
        tests++;
        if (cwso !== 1'b0) begin
            fails++;
            $display("FAIL cw_fwd_clear: cwso=%b required 0", cwso);
        end
    endtask

    task automatic test_ccw_to_pe();
        logic [63:0] exp;
        wait_pol(1'b1);
        ccwsi = 1'b1;
        ccwdi = mk(1'b0, 1'b1, 8'h00, 48'hDEAD_BEEF_0001);
        exp   = mk(1'b1, 1'b1, 8'h00, 48'hDEAD_BEEF_0001);
        tick();
        ccwsi = 1'b0;
        tick();
        tests++;
        if (peso !== 1'b1 || pedo !== exp) begin
            fails++;
            $display("FAIL ccw_pe_data: peso=%b pedo=%h required 1/%h", peso, pedo, exp);
        end
        tests++;
        if ({cwso, ccwso} !== 2'b00) begin
            fails++;
            $display("FAIL ccw_pe_others: cwso/ccwso=%b required 00", {cwso, ccwso});
        end
        tick();
        tests++;
        if (peso !== 1'b0) begin
            fails++;
            $display("FAIL ccw_pe_clear: peso=%b required 0", peso);
        end
    endtask

    // Two contended rounds on cw output VC0: cw wins first, then the flipped pointer favours PE
    task automatic test_contention();
        logic [63:0] a, b, ea, eb, first, second;
        a  = mk(1'b0, 1'b0, 8'h04, 48'hAAAA_0000_0001);
        b  = mk(1'b0, 1'b0, 8'h33, 48'hBBBB_0000_0002);
        ea = mk(1'b0, 1'b0, 8'h02, 48'hAAAA_0000_0001);
        eb = b;
        for (int round = 0; round < 2; round++) begin
            first  = (round == 0) ? ea : eb;
            second = (round == 0) ? eb : ea;
            wait_pol(1'b0);
            cwsi = 1'b1; cwdi = a;
            pesi = 1'b1; pedi = b;
            tick();
            cwsi = 1'b0; pesi = 1'b0;
            tick();
            tests++;
            if (cwso !== 1'b1 || cwdo !== first) begin
                fails++;
                $display("FAIL contend_first[%0d]: cwso=%b cwdo=%h required 1/%h", round, cwso,
                         cwdo, first);
            end
            tick();
            tests++;
            if (cwso !== 1'b0) begin
                fails++;
                $display("FAIL contend_gap[%0d]: cwso=%b required 0", round, cwso);
            end
            tick();
            tests++;
            if (cwso !== 1'b1 || cwdo !== second) begin
                fails++;
                $display("FAIL contend_second[%0d]: cwso=%b cwdo=%h required 1/%h", round, cwso,
                         cwdo, second);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] pk  [4];
        logic [63:0] exp [4];
        int  sent, recv;
        logic saw_full;
        for (int i = 0; i < 4; i++) begin
            pk[i]  = mk(1'b0, 1'b0, 8'(2 * (i + 1)), 48'(32'hC0DE_0000 + i));
            exp[i] = mk(1'b0, 1'b0, 8'(i + 1), 48'(32'hC0DE_0000 + i));
        end
        cwro = 1'b0;
        sent = 0;
        saw_full = 1'b0;
        wait_pol(1'b0);
        for (int c = 0; c < 20 && !saw_full; c++) begin
            cwsi = 1'b0;
            if (polarity == 1'b0) begin
                if (cwso === 1'b1) begin
                    tests++;
                    if (cwdo !== exp[0]) begin
                        fails++;
                        $display("FAIL bp_hold: cwdo=%h required %h", cwdo, exp[0]);
                    end
                end
                if (cwri !== 1'b1) begin
                    saw_full = 1'b1;
                end else if (sent < 4) begin
                    cwsi = 1'b1;
                    cwdi = pk[sent];
                    sent++;
                end
            end
            if (!saw_full) tick();
        end
        cwsi = 1'b0;
        tests++;
        if (!saw_full || sent != 3) begin
            fails++;
            $display("FAIL bp_accept: full=%b accepted=%0d required 1/3", saw_full, sent);
        end
        cwro = 1'b1;
        recv = 0;
        for (int c = 0; c < 30; c++) begin
            if (cwso === 1'b1) begin
                tests++;
                if (recv >= 3 || cwdo !== exp[recv]) begin
                    fails++;
                    $display("FAIL bp_order[%0d]: cwdo=%h required %h", recv, cwdo,
                             exp[recv < 3 ? recv : 3]);
                end
                recv++;
            end
            tick();
        end
        tests++;
        if (recv != 3) begin
            fails++;
            $display("FAIL bp_count: delivered=%0d required 3", recv);
        end
    endtask

    task automatic test_reset_midflight();
        cwro = 1'b0; ccwro = 1'b0; pero = 1'b0;
        wait_pol(1'b0);
        cwsi  = 1'b1; cwdi  = mk(1'b0, 1'b0, 8'h05, 48'h0000_0000_0011);
        ccwsi = 1'b1; ccwdi = mk(1'b0, 1'b1, 8'h03, 48'h0000_0000_0022);
        pesi  = 1'b1; pedi  = mk(1'b0, 1'b1, 8'h09, 48'h0000_0000_0033);
        tick();
        cwsi = 1'b0; ccwsi = 1'b0; pesi = 1'b0;
        repeat (3) tick();
        tests++;
        if ({cwso, ccwso} !== 2'b11 && {cwso, ccwso} !== 2'b00) begin
            fails++;
            $display("FAIL midflight_pre: cwso/ccwso=%b required matching phase", {cwso, ccwso});
        end
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        cwro = 1'b1; ccwro = 1'b1; pero = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tests++;
            if ({cwso, ccwso, peso} !== 3'b000) begin
                fails++;
                $display("FAIL midflight_so[%0d]: so=%b required 000", c, {cwso, ccwso, peso});
            end
            tick();
        end
        tests++;
        if ({cwri, ccwri, peri} !== 3'b111) begin
            fails++;
            $display("FAIL midflight_ri: ri=%b required 111", {cwri, ccwri, peri});
        end
    endtask

    initial begin
        test_reset();
        test_cw_forward();
        test_ccw_to_pe();
        test_contention();
        test_backpressure();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gold_router_vc.md
GOLD_ROUTER_VC -- requirements
Module: gold_router_vc

Interface
REQ-001 The block SHALL have parameter PACKET_SIZE, default 64, giving the packet width in bits (minimum 16).
REQ-002 The block SHALL have parameter BUF_DEPTH, default 2, giving the input FIFO entries per input per VC (power of two, minimum 1).
REQ-003 The block SHALL have parameter HOP_W, default 8, giving the hop field width located at [PACKET_SIZE-9 -: HOP_W].
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port polarity, output, 1 bit: current phase, 0 = even, 1 = odd.
REQ-008 Ports cwsi, ccwsi and pesi, input, 1 bit each: input valid for the cw, ccw and PE inputs.
REQ-009 Ports cwri, ccwri and peri, output, 1 bit each: input ready for the cw, ccw and PE inputs.
REQ-010 Ports cwdi, ccwdi and pedi, input, PACKET_SIZE bits each: input packet data.
REQ-011 Ports cwso, ccwso and peso, output, 1 bit each: output valid for the cw, ccw and PE outputs.
REQ-012 Ports cwro, ccwro and pero, input, 1 bit each: downstream ready for the cw, ccw and PE outputs.
REQ-013 Ports cwdo, ccwdo and pedo, output, PACKET_SIZE bits each: output packet data.

Function
REQ-014 Packet fields SHALL be: VC = bit PACKET_SIZE-1; dir = bit PACKET_SIZE-2 (0 = cw, 1 = ccw); hop = HOP_W bits at [PACKET_SIZE-9 -: HOP_W]; all other bits pass through unmodified.
REQ-015 polarity SHALL be a register that is 0 in the first cycle after reset deasserts and toggles on every clock edge thereafter.
REQ-016 Each input SHALL hold two FIFOs, VC0 and VC1, of BUF_DEPTH entries each; each output SHALL hold two single-entry registers, VC0 and VC1.
REQ-017 External phase: an input transfer SHALL occur when xsi && xri at the edge and SHALL write FIFO[polarity]; the incoming VC bit SHALL be ignored.
REQ-018 xri SHALL equal !full(FIFO[polarity]) of that input.
REQ-019 Output valid: xso SHALL equal valid(outreg[polarity]); xdo SHALL equal outreg[polarity] with the VC bit forced to polarity.
REQ-020 Output transfer: when xso && xro at the edge, outreg[polarity] SHALL clear; when xro = 0, data SHALL be held stable.
REQ-021 Internal phase: in the same cycle, each non-empty FIFO[!polarity] head SHALL request a move into the outreg[!polarity] of its target output.
REQ-022 A move SHALL occur only if the target outreg is empty and the request is granted; the FIFO SHALL pop at the same edge.
REQ-023 Routing from the cw or ccw input: hop == 0 SHALL target the PE output with the packet unchanged; hop != 0 SHALL target the same-direction output with hop shifted right by 1.
REQ-024 Routing from the PE input: dir = 0 SHALL target the cw output and dir = 1 SHALL target the ccw output, with hop unchanged.
REQ-025 Contention SHALL be resolved per output per VC: cw output between cw and PE inputs; ccw output between ccw and PE inputs; PE output between cw and ccw inputs.
REQ-026 Each (output, VC) pair SHALL keep a 1-bit round-robin pointer, reset to 0; value 0 SHALL favour the ring-side input, and for the PE output value 0 SHALL favour cw.
REQ-027 The pointer SHALL toggle only when both contenders request in the same cycle and a grant issues; the loser SHALL remain at its FIFO head.
REQ-028 Minimum latency SHALL be: accept at edge k, xso high during cycle k+1..k+2, transfer at edge k+2.
REQ-029 Per-input, per-VC ordering SHALL be preserved, and no packet SHALL be dropped or duplicated.
REQ-030 A full FIFO SHALL accept nothing; a simultaneous pop of the same FIFO is impossible by phase separation and SHALL NOT be handled as a case.

Reset
REQ-031 While reset = 1, all FIFOs and outregs SHALL be emptied, pointers set to 0 and polarity set to 0, at the clock edge.
REQ-032 During reset, cwso, ccwso and peso SHALL be 0, and cwri, ccwri and peri SHALL be 1 from the first post-reset cycle.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered packets with no output at all.

Verification
REQ-034 Hold reset 5 cycles, then release -> polarity reads 0,1,0,1...; all ri = 1; all so = 0.
REQ-035 cwsi = 1 with hop 8'h0F while polarity = 0, all ro = 1 -> cwso high 1 cycle later with hop 8'h07 and bit 63 = 0; peso and ccwso stay 0.
REQ-036 ccwsi = 1 with hop 8'h00 while polarity = 1 -> peso with pedo == ccwdi and bit 63 = 1, 2 edges after acceptance.
REQ-037 cw input (hop 8'h04) and PE input (dir 0) on the same edge -> cwdo first carries hop 8'h02 from cw, then the PE packet 2 cycles later; the pointer flips to PE.
REQ-038 Hold cwro = 0 and send cw packets on VC0 -> BUF_DEPTH+1 accepted, then cwri = 0 in the even phase; raise cwro -> all packets delivered in order.
REQ-039 Assert reset while 3 packets are buffered -> no so asserted afterwards and all ri = 1.
